// File: rtl/pc_flag_unit.sv
// Z/N/V flag register and PC sequencer: per-opcode flag updates, same-cycle flag
// bypass into B/BR condition evaluation, and a sticky HALT state left only by reset.
module pc_flag_unit #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
  input  logic        br_valid,
  input  logic [3:0]  br_opcode,
  input  logic [2:0]  br_cond,
  input  logic [8:0]  br_imm,
  input  logic [15:0] br_reg,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic        branch_taken,
  output logic        halted
);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_XOR = 4'b0010,
                         OP_SLL = 4'b0100, OP_SRA = 4'b0101, OP_ROR = 4'b0110,
                         OP_B   = 4'b1100, OP_BR  = 4'b1101, OP_HLT = 4'b1111;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt, w_b_tgt;
  logic        r_z, r_n, r_v;
  logic        w_active, w_upd_z, w_upd_nv;
  logic        w_eff_z, w_eff_n, w_eff_v, w_cond;
  logic        w_is_b, w_is_br, w_is_hlt, w_taken;

  // Nothing architectural moves while stalled or halted.
  assign w_active = !stall && (r_state == S_RUN);

  always_comb begin
    w_upd_z  = 1'b0;
    w_upd_nv = 1'b0;
    if (ex_valid && w_active) begin
      case (ex_opcode)
        OP_ADD, OP_SUB:                 begin w_upd_z = 1'b1; w_upd_nv = 1'b1; end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_upd_z = 1'b1;
        default: ;
      endcase
    end
  end

  // Per-bit bypass so a branch sees the flags of the instruction just ahead of it.
  assign w_eff_z = w_upd_z  ? alu_z : r_z;
  assign w_eff_n = w_upd_nv ? alu_n : r_n;
  assign w_eff_v = w_upd_nv ? alu_v : r_v;

  always_comb begin
    w_cond = 1'b0;
    case (br_cond)
      3'b000: w_cond = !w_eff_z;
      3'b001: w_cond = w_eff_z;
      3'b010: w_cond = !w_eff_z && !w_eff_n;
      3'b011: w_cond = w_eff_n;
      3'b100: w_cond = w_eff_z || (!w_eff_z && !w_eff_n);
      3'b101: w_cond = w_eff_n || w_eff_z;
      3'b110: w_cond = w_eff_v;
      3'b111: w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_is_b   = br_valid && (br_opcode == OP_B);
  assign w_is_br  = br_valid && (br_opcode == OP_BR);
  assign w_is_hlt = br_valid && (br_opcode == OP_HLT);
  assign w_taken  = (w_is_b || w_is_br) && w_cond && w_active;

  assign pc_plus2 = r_pc + 16'd2;
  assign w_b_tgt  = pc_plus2 + {{6{br_imm[8]}}, br_imm, 1'b0};

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_active) begin
      if (w_taken && w_is_b)       w_pc_nxt = w_b_tgt;
      else if (w_taken && w_is_br) w_pc_nxt = br_reg;
      else if (!w_is_hlt)          w_pc_nxt = pc_plus2;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_RUN && w_is_hlt && !stall) w_state_nxt = S_HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= PC_RESET;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_upd_z) r_z <= alu_z;
      if (w_upd_nv) begin
        r_n <= alu_n;
        r_v <= alu_v;
      end
    end
  end

  assign pc           = r_pc;
  assign flag_z       = r_z;
  assign flag_n       = r_n;
  assign flag_v       = r_v;
  assign halted       = (r_state == S_HALT);
  assign branch_taken = w_taken && !rst;

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pc_flag_unit;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic        ex_valid = 1'b0, alu_z = 1'b0, alu_n = 1'b0, alu_v = 1'b0;
  logic [3:0]  ex_opcode = 4'h0, br_opcode = 4'h0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_cond = 3'h0;
  logic [8:0]  br_imm = 9'h0;
  logic [15:0] br_reg = 16'h0;
  logic [15:0] pc, pc_plus2;
  logic        flag_z, flag_n, flag_v, branch_taken, halted;

  int n_checks = 0, n_errors = 0;
  logic [15:0] m_pc = 16'h0;
  logic        m_z = 1'b0, m_n = 1'b0, m_v = 1'b0, m_halt = 1'b0;
  logic        obs_taken;

  pc_flag_unit #(.PC_RESET(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .br_valid(br_valid), .br_opcode(br_opcode),
    .br_cond(br_cond), .br_imm(br_imm), .br_reg(br_reg), .pc(pc), .pc_plus2(pc_plus2),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .branch_taken(branch_taken),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model, check state.
  task automatic step(input logic r, input logic s, input logic exv, input logic [3:0] exop,
                      input logic [2:0] znv, input logic brv, input logic [3:0] brop,
                      input logic [2:0] cond, input logic [8:0] imm, input logic [15:0] rg);
    logic en, upd_z, upd_nv, ez, enf, ev, ct, is_b, is_br, tk;
    int off;
    @(negedge clk);
    rst = r; stall = s; ex_valid = exv; ex_opcode = exop;
    {alu_z, alu_n, alu_v} = znv; br_valid = brv; br_opcode = brop;
    br_cond = cond; br_imm = imm; br_reg = rg;
    #1;
    tk = 1'b0;
    if (r) begin
      m_pc = 16'h0; m_z = 0; m_n = 0; m_v = 0; m_halt = 0;
    end else begin
      en     = !s && !m_halt;
      upd_z  = en && exv && (exop inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6});
      upd_nv = en && exv && (exop inside {4'd0, 4'd1});
      ez  = upd_z  ? znv[2] : m_z;
      enf = upd_nv ? znv[1] : m_n;
      ev  = upd_nv ? znv[0] : m_v;
      case (cond)
        3'd0: ct = !ez;
        3'd1: ct = ez;
        3'd2: ct = !ez && !enf;
        3'd3: ct = enf;
        3'd4: ct = ez || !enf;
        3'd5: ct = enf || ez;
        3'd6: ct = ev;
        default: ct = 1'b1;
      endcase
      is_b  = brv && brop == 4'hC;
      is_br = brv && brop == 4'hD;
      tk = en && ct && (is_b || is_br);
    end
    obs_taken = branch_taken;
    chk("taken", {31'd0, branch_taken}, {31'd0, tk});
    chk("pc_plus2", {16'd0, pc_plus2}, {16'd0, m_pc + 16'd2});
    if (!r && en) begin
      off = imm[8] ? int'(imm) - 512 : int'(imm);
      if (tk && is_b)                  m_pc = 16'(int'(m_pc) + 2 + 2 * off);
      else if (tk && is_br)            m_pc = rg;
      else if (brv && brop == 4'hF)    m_halt = 1'b1;
      else                             m_pc = m_pc + 16'd2;
      m_z = ez; m_n = enf; m_v = ev;
    end
    @(posedge clk); #1;
    chk("pc", {16'd0, pc}, {16'd0, m_pc});
    chk("flags", {29'd0, flag_z, flag_n, flag_v}, {29'd0, m_z, m_n, m_v});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
  endtask

  task automatic idle();
    step(0, 0, 0, 4'h3, 3'b000, 0, 4'h0, 3'd0, 9'h0, 16'h0);
  endtask
  task automatic jump(input logic [15:0] tgt);
    step(0, 0, 0, 4'h3, 3'b000, 1, 4'hD, 3'd7, 9'h0, tgt);
  endtask
  task automatic set_flags(input logic [2:0] znv);
    step(0, 0, 1, 4'h0, znv, 0, 4'h0, 3'd0, 9'h0, 16'h0);
  endtask
  task automatic do_reset();
    step(1, 0, 0, 4'h0, 3'b000, 0, 4'h0, 3'd0, 9'h0, 16'h0);
    step(1, 0, 0, 4'h0, 3'b000, 0, 4'h0, 3'd0, 9'h0, 16'h0);
  endtask

  initial begin
    int unsigned sel;
    logic [3:0] bop;
    // Reset and idle sequencing
    do_reset();
    chk("rst_pc", {16'd0, pc}, 32'h0);
    chk("rst_flags", {29'd0, flag_z, flag_n, flag_v}, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'h0);
    repeat (3) idle();
    chk("idle_pc", {16'd0, pc}, 32'h0006);

    // Bypass of Z from a same-cycle ADD
    do_reset();
    jump(16'h0010);
    step(0, 0, 1, 4'h0, 3'b100, 1, 4'hC, 3'd1, 9'h004, 16'h0);
    chk("byp_taken", {31'd0, obs_taken}, 32'h1);
    chk("byp_pc", {16'd0, pc}, 32'h001A);
    chk("byp_z", {31'd0, flag_z}, 32'h1);

    // XOR touches Z only
    set_flags(3'b011);
    step(0, 0, 1, 4'h2, 3'b100, 0, 4'h0, 3'd0, 9'h0, 16'h0);
    chk("xor_flags", {29'd0, flag_z, flag_n, flag_v}, 32'h7);

    // Negative branch offsets
    jump(16'h0010);
    step(0, 0, 0, 4'h3, 3'b000, 1, 4'hC, 3'd7, 9'h1FF, 16'h0);
    chk("neg1_pc", {16'd0, pc}, 32'h0010);
    step(0, 0, 0, 4'h3, 3'b000, 1, 4'hC, 3'd7, 9'h100, 16'h0);
    chk("negmax_pc", {16'd0, pc}, 32'hFE12);

    // Stall holds PC and flags; then wrap
    jump(16'hFFFE);
    repeat (2) step(0, 1, 1, 4'h0, 3'b000, 1, 4'hC, 3'd7, 9'h004, 16'h0);
    chk("stall_pc", {16'd0, pc}, 32'hFFFE);
    chk("stall_flags", {29'd0, flag_z, flag_n, flag_v}, 32'h7);
    idle();
    chk("wrap_pc", {16'd0, pc}, 32'h0000);

    // BR on overflow, then HLT
    set_flags(3'b000);
    step(0, 0, 0, 4'h3, 3'b000, 1, 4'hD, 3'd6, 9'h0, 16'h1234);
    chk("br_nov_pc", {16'd0, pc}, 32'h0004);
    set_flags(3'b001);
    step(0, 0, 0, 4'h3, 3'b000, 1, 4'hD, 3'd6, 9'h0, 16'h1234);
    chk("br_ov_pc", {16'd0, pc}, 32'h1234);
    step(0, 0, 0, 4'h3, 3'b000, 1, 4'hF, 3'd0, 9'h0, 16'h0);
    chk("hlt", {31'd0, halted}, 32'h1);
    repeat (5) step(0, 0, 1, 4'h0, 3'b111, 1, 4'hC, 3'd7, 9'h010, 16'h0);
    chk("hlt_pc", {16'd0, pc}, 32'h1234);
    do_reset();
    chk("hlt_rst_pc", {16'd0, pc}, 32'h0);
    chk("hlt_rst_halted", {31'd0, halted}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 39);
      bop = (sel < 14) ? 4'hC : (sel < 26) ? 4'hD : (sel == 26) ? 4'hF : 4'($urandom);
      step($urandom_range(0, 79) == 0, $urandom_range(0, 4) == 0, 1'($urandom),
           4'($urandom), 3'($urandom), $urandom_range(0, 3) != 0, bop,
           3'($urandom), 9'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
